arbiter_2_to_1: RTL and testbench
=================================

Name: arbiter_2_to_1

Overview:
- Clocked 2-input, 1-output packet arbiter with round-robin fairness and a single registered output stage.
- Merges two packet streams onto one link.
- Instantiated inside output_ctrl of the tree NoC router (the in1/in2 to out merge).
- Packets pass through unmodified.

Parameters:
- WIDTH, 14: packet width in bits (from the shared package WIDTH_PACKET).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in1_data  input  WIDTH  packet from source 1.
- in1_valid  input  1  source 1 offers a packet.
- in1_ready  output  1  arbiter accepts in1_data this cycle.
- in2_data  input  WIDTH  packet from source 2.
- in2_valid  input  1  source 2 offers a packet.
- in2_ready  output  1  arbiter accepts in2_data this cycle.
- out_data  output  WIDTH  registered output packet.
- out_valid  output  1  out_data holds a valid packet.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Handshake: a transfer occurs on a rising edge where valid && ready. Sources hold valid and data stable until accepted. The arbiter holds out_valid and out_data stable while out_valid && !out_ready.
- Output register: `slot_free = !out_valid || out_ready` (combinational).
- At most one input is accepted per cycle.
  - in1_ready = slot_free && grant1.
  - in2_ready = slot_free && grant2.
  - Both readies are combinational from the valids, out_ready, out_valid and the priority pointer.
  - Neither ready is ever high while rst = 1.
- Grant rules:
  - Only in1_valid: grant1.
  - Only in2_valid: grant2.
  - Both valid: grant the input that did not win the last arbitration (round-robin).
  - Neither valid: no grant.
- Priority pointer (`last`, 1 bit, 0 = in1 won last):
  - Updates only on an accepted transfer: set to 0 when in1 is accepted, 1 when in2 is accepted.
  - Reset value is 1, so in1 wins the first contention.
- Register update on an accepted input: out_data <= accepted data, out_valid <= 1.
- Else if out_valid && out_ready: out_valid <= 0 (out_data keeps its last value).
- Else: hold.
- Latency: a packet accepted at edge N is presented on out_data/out_valid after edge N and can leave at edge N+1 at the earliest.
- Throughput: 1 packet/cycle with out_ready held high, including back-to-back alternation under contention (in1, in2, in1, ...).
- Back-pressure: while out_valid=1 and out_ready=0, both readies are 0 and the pointer does not change. A requester waiting under contention keeps its priority.
- Ordering: packets from the same input leave in arrival order. No drops, no duplication.
- Reset (synchronous, rst=1 at a rising edge): out_valid <= 0, out_data <= 0, last <= 1.
- Reset mid-operation: any packet held in the output register is discarded and input readies go low immediately.
- Simultaneous events: one-packet departure plus new acceptance in the same cycle is legal and required; the register is overwritten with the new packet.
- No X propagation: out_data is never driven from an unaccepted input.

Decomposition:
- Shared package noc_pkg:
  - WIDTH_PACKET = 14.
  - typedef logic [WIDTH_PACKET-1:0] packet_t.
  - Reused by output_ctrl and the router.
- Optional sub-module rr_pick2: purely combinational 2-way round-robin grant (inputs req[1:0], last; outputs gnt[1:0]). Its outputs feed the readies and the pointer update.
- The output register and pointer live in arbiter_2_to_1.

Test Plan:
- Reset: rst=1 for 2 cycles with both inputs valid -> out_valid=0, out_data=0, in1_ready=in2_ready=0. After release with out_ready=1, the first accepted packet is from in1.
- Single source:
  - Stimulus: in1 sends 14'h0001, 14'h0002, 14'h0003 back to back; in2 idle; out_ready=1.
  - Response: out_data shows 0001, 0002, 0003 on three consecutive cycles, each one cycle after acceptance.
- Contention fairness:
  - Stimulus: in1 holds 14'h1AAA, in2 holds 14'h2555 continuously (new packet each accept); out_ready=1.
  - Response: outputs strictly alternate 1AAA, 2555, 1AAA, 2555, ... with 1 packet/cycle.
- Back-pressure:
  - Stimulus: out_ready=0 for 5 cycles with out_valid=1 holding 14'h0ABC.
  - Response: out_data stays 0ABC, both readies 0, pointer unchanged. Raising out_ready drains 0ABC and accepts the next packet at the same edge.
- Mid-operation reset: assert rst while out_valid=1 with 14'h3FFF held -> next cycle out_valid=0, out_data=0, and 3FFF is never delivered.
- Random valid/ready traffic, 1000 packets per input -> scoreboard shows per-input order preserved, no loss or duplicates, and no starvation (each waiting input is served within 2 accepted transfers).

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: packet width and type shared across the tree NoC router.
package noc_pkg;
  localparam int WIDTH_PACKET = 14;
  typedef logic [WIDTH_PACKET-1:0] packet_t;
endpackage

// File: rtl/arbiter_2_to_1_rr_pick2.sv
// rr_pick2: combinational two-way round-robin grant; last=1 means requester 1 won last time.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt[0] = req[0] && (!req[1] || last);
    gnt[1] = req[1] && (!req[0] || !last);
  end
endmodule

// File: rtl/arbiter_2_to_1.sv
// arbiter_2_to_1: merges two packet streams onto one link through a single output register.
module arbiter_2_to_1
  import noc_pkg::*;
#(
  parameter int WIDTH = WIDTH_PACKET
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in2_data,
  input  logic             in2_valid,
  output logic             in2_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             last_q, last_d;
  logic [1:0]       gnt;
  logic             slot_free, acc1, acc2;
  rr_pick2 u_pick (
    .req  ({in2_valid, in1_valid}),
    .last (last_q),
    .gnt  (gnt)
  );
  // rst gates the readies so nothing is accepted in the reset cycle
  always_comb begin
    slot_free   = !out_valid_q || out_ready;
    in1_ready   = !rst && slot_free && gnt[0];
    in2_ready   = !rst && slot_free && gnt[1];
    acc1        = in1_valid && in1_ready;
    acc2        = in2_valid && in2_ready;
    out_data_d  = acc1 ? in1_data : acc2 ? in2_data : out_data_q;
    out_valid_d = (acc1 || acc2) ? 1'b1 : (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
    last_d      = acc1 ? 1'b0 : acc2 ? 1'b1 : last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_arbiter_2_to_1.sv
// tb_arbiter_2_to_1: directed vector table plus random scoreboard traffic.
module tb_arbiter_2_to_1;
  logic clk = 0, rst = 1;
  logic [13:0] in1_data = '0, in2_data = '0, out_data;
  logic in1_valid = 0, in2_valid = 0, out_ready = 0;
  logic in1_ready, in2_ready, out_valid;
  int total = 0, bad = 0;
  arbiter_2_to_1 dut (
    .clk(clk), .rst(rst),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .in2_data(in2_data), .in2_valid(in2_valid), .in2_ready(in2_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst, v1, v2, ordy;
    logic [13:0] d1, d2;
    logic r1, r2, ov;
    logic [13:0] od;
  } vec_t;
  vec_t tv[22];
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic vec_t mk(logic r, logic v1, logic [13:0] d1, logic v2, logic [13:0] d2,
                              logic ordy, logic r1, logic r2, logic ov, logic [13:0] od);
    vec_t v;
    v.rst = r; v.v1 = v1; v.d1 = d1; v.v2 = v2; v.d2 = d2; v.ordy = ordy;
    v.r1 = r1; v.r2 = r2; v.ov = ov; v.od = od;
    return v;
  endfunction
  int sent1, sent2, exp1, exp2, w1, w2, cyc;
  logic acc1, acc2, dep;
  initial begin
    //            rst v1 d1       v2 d2       ordy r1 r2 ov od
    tv[0]  = mk(1, 1, 14'h1AAA, 1, 14'h2555, 1, 0, 0, 0, 14'h0000);
    tv[1]  = mk(1, 1, 14'h1AAA, 1, 14'h2555, 1, 0, 0, 0, 14'h0000);
    tv[2]  = mk(0, 1, 14'h1AAA, 1, 14'h2555, 1, 1, 0, 1, 14'h1AAA);
    tv[3]  = mk(0, 1, 14'h1AAA, 1, 14'h2555, 1, 0, 1, 1, 14'h2555);
    tv[4]  = mk(0, 1, 14'h1AAA, 1, 14'h2555, 1, 1, 0, 1, 14'h1AAA);
    tv[5]  = mk(0, 1, 14'h1AAA, 1, 14'h2555, 1, 0, 1, 1, 14'h2555);
    tv[6]  = mk(0, 1, 14'h0001, 0, 14'h0000, 1, 1, 0, 1, 14'h0001);
    tv[7]  = mk(0, 1, 14'h0002, 0, 14'h0000, 1, 1, 0, 1, 14'h0002);
    tv[8]  = mk(0, 1, 14'h0003, 0, 14'h0000, 1, 1, 0, 1, 14'h0003);
    tv[9]  = mk(0, 0, 14'h0000, 0, 14'h0000, 1, 0, 0, 0, 14'h0003);
    tv[10] = mk(0, 1, 14'h0ABC, 0, 14'h0000, 0, 1, 0, 1, 14'h0ABC);
    for (int i = 11; i < 16; i++)
      tv[i] = mk(0, 1, 14'h1111, 1, 14'h2222, 0, 0, 0, 1, 14'h0ABC);
    tv[16] = mk(0, 1, 14'h1111, 1, 14'h2222, 1, 0, 1, 1, 14'h2222);
    tv[17] = mk(0, 1, 14'h3FFF, 0, 14'h0000, 1, 1, 0, 1, 14'h3FFF);
    tv[18] = mk(0, 0, 14'h0000, 0, 14'h0000, 0, 0, 0, 1, 14'h3FFF);
    tv[19] = mk(1, 1, 14'h1234, 1, 14'h2345, 0, 0, 0, 0, 14'h0000);
    tv[20] = mk(0, 1, 14'h0555, 1, 14'h0666, 1, 1, 0, 1, 14'h0555);
    tv[21] = mk(0, 0, 14'h0000, 0, 14'h0000, 1, 0, 0, 0, 14'h0555);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rst = tv[i].rst; in1_valid = tv[i].v1; in1_data = tv[i].d1;
      in2_valid = tv[i].v2; in2_data = tv[i].d2; out_ready = tv[i].ordy;
      #1;
      chk($sformatf("v%0d in1_ready", i), int'(in1_ready), int'(tv[i].r1));
      chk($sformatf("v%0d in2_ready", i), int'(in2_ready), int'(tv[i].r2));
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), int'(out_valid), int'(tv[i].ov));
      chk($sformatf("v%0d out_data", i), int'(out_data), int'(tv[i].od));
    end
    // random traffic: bit 13 tags the source, low bits carry a sequence number
    in1_valid = 0; in2_valid = 0;
    sent1 = 0; sent2 = 0; exp1 = 0; exp2 = 0; w1 = 0; w2 = 0; cyc = 0;
    while ((exp1 < 1000 || exp2 < 1000) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (!in1_valid && sent1 < 1000 && $urandom_range(0, 3) != 0) begin
        in1_valid = 1; in1_data = {1'b0, 13'(sent1)};
      end
      if (!in2_valid && sent2 < 1000 && $urandom_range(0, 3) != 0) begin
        in2_valid = 1; in2_data = {1'b1, 13'(sent2)};
      end
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      acc1 = in1_valid && in1_ready;
      acc2 = in2_valid && in2_ready;
      dep = out_valid && out_ready;
      if (acc1 && acc2) chk("one_accept", 2, 1);
      if (dep) begin
        if (out_data[13]) begin
          chk("in2_order", int'(out_data[12:0]), exp2); exp2++;
        end else begin
          chk("in1_order", int'(out_data[12:0]), exp1); exp1++;
        end
      end
      if (acc2 && in1_valid) w1++;
      if (acc1 && in2_valid) w2++;
      if (acc1) begin chk("in1_starve", int'(w1 <= 1), 1); w1 = 0; end
      if (acc2) begin chk("in2_starve", int'(w2 <= 1), 1); w2 = 0; end
      @(posedge clk); #1;
      if (acc1) begin in1_valid = 0; sent1++; end
      if (acc2) begin in2_valid = 0; sent2++; end
    end
    chk("in1_count", exp1, 1000);
    chk("in2_count", exp2, 1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
